// File: rtl/imem_pkg.sv
// Shared types and constants for the writable instruction memory.
// Holds the loader state enum, default NOP encoding and word sizing helper.
package imem_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2
  } imem_state_e;

  localparam logic [31:0] NOP_WORD_DEF = 32'h0000_0013;

  function automatic int bytes_per_word(input int w);
    return w / 8;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-port synchronous RAM, one registered read port and a write enable.
// Contents are never cleared; the read register holds until the next read.
module imem_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16384,
  parameter int AW     = 14
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/imem_loader.sv
// Writable instruction memory: fetch port in RUN, UART byte loader in LOAD.
// Define IMEM_FAULT_EN to return NOP_WORD with f_fault on fetches >= DEPTH.
module imem_loader
  import imem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 14,
  parameter int DEPTH  = 16384,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(NOP_WORD_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              prog_mode,
  input  logic              ld_valid,
  input  logic [7:0]        ld_byte,
  output logic              ld_ready,
  output logic [ADDR_W:0]   ld_count,
  output logic              ld_ovf,
  input  logic              f_req,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_valid,
  output logic [DATA_W-1:0] f_data,
  output logic              f_fault
);

  localparam int BPW = bytes_per_word(DATA_W);
  localparam int IW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int RAW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [IW-1:0]   LAST_IDX = IW'(BPW - 1);

  imem_state_e       state_q, state_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [DATA_W-1:0] asm_q, asm_d;
  logic [DATA_W-1:0] asm_ins;
  logic [ADDR_W:0]   wcnt_q, wcnt_d;
  logic              ovf_q, ovf_d;

  logic              commit;
  logic              we;
  logic [DATA_W-1:0] wdata;
  logic              acc;

  logic              fire, flt, re;
  logic [RAW-1:0]    raddr, ram_addr;
  logic [DATA_W-1:0] rdata;
  logic              fv_q, flt_q, have_q;

  assign acc = ld_valid && (state_q == LOAD);

  always_comb begin
    asm_ins = asm_q;
    asm_ins[8*int'(idx_q) +: 8] = ld_byte;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    wcnt_d  = wcnt_q;
    ovf_d   = ovf_q;
    commit  = 1'b0;
    we      = 1'b0;
    wdata   = asm_ins;
    unique case (state_q)
      RUN: begin
        if (prog_mode) begin
          state_d = LOAD;
          idx_d   = '0;
          asm_d   = '0;
          wcnt_d  = '0;
          ovf_d   = 1'b0;
        end
      end
      LOAD: begin
        if (acc) begin
          if (idx_q == LAST_IDX) begin
            commit = 1'b1;
            idx_d  = '0;
            asm_d  = '0;
          end else begin
            asm_d = asm_ins;
            idx_d = idx_q + 1'b1;
          end
        end
        // a byte in the same cycle as the mode drop still counts
        if (!prog_mode) state_d = (idx_d == '0) ? RUN : FLUSH;
      end
      FLUSH: begin
        commit  = 1'b1;
        wdata   = asm_q;
        idx_d   = '0;
        asm_d   = '0;
        state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    if (commit) begin
      if (wcnt_q < DEPTH_C) begin
        we     = 1'b1;
        wcnt_d = wcnt_q + 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      idx_q   <= '0;
      asm_q   <= '0;
      wcnt_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      wcnt_q  <= wcnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign fire = f_req && (state_q == RUN);

`ifdef IMEM_FAULT_EN
  assign flt   = ({1'b0, f_addr} >= DEPTH_C);
  assign raddr = f_addr[RAW-1:0];
`else
  logic unused_addr;
  assign unused_addr = ^f_addr;
  assign flt   = 1'b0;
  assign raddr = f_addr[RAW-1:0];
`endif

  assign re       = fire && !flt;
  assign ram_addr = we ? wcnt_q[RAW-1:0] : raddr;

  imem_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAW)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .re_i    (re),
    .addr_i  (ram_addr),
    .wdata_i (wdata),
    .rdata_o (rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fv_q   <= 1'b0;
      flt_q  <= 1'b0;
      have_q <= 1'b0;
    end else begin
      fv_q <= fire;
      if (fire) begin
        flt_q  <= flt;
        have_q <= 1'b1;
      end
    end
  end

  assign f_valid  = fv_q;
  assign f_fault  = fv_q && flt_q;
  assign f_data   = !have_q ? '0 : (flt_q ? NOP_WORD : rdata);
  assign ld_ready = (state_q == LOAD);
  assign ld_count = wcnt_q;
  assign ld_ovf   = ovf_q;

endmodule

// File: tb/tb_imem_loader.sv
// Randomised bench for imem_loader against a byte-queue reference model.
// Small DEPTH so overflow and out-of-range fetches are reachable.
module tb_imem_loader;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int DEPTH = 8;
  localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef IMEM_FAULT_EN
  localparam bit FAULT = 1'b1;
`else
  localparam bit FAULT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          prog_mode = 1'b0;
  logic          ld_valid = 1'b0;
  logic [7:0]    ld_byte = '0;
  logic          ld_ready;
  logic [AW:0]   ld_count;
  logic          ld_ovf;
  logic          f_req = 1'b0;
  logic [AW-1:0] f_addr = '0;
  logic          f_valid;
  logic [DW-1:0] f_data;
  logic          f_fault;

  always #5 clk = ~clk;

  imem_loader #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .DEPTH    (DEPTH),
    .NOP_WORD (NOP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .prog_mode (prog_mode),
    .ld_valid  (ld_valid),
    .ld_byte   (ld_byte),
    .ld_ready  (ld_ready),
    .ld_count  (ld_count),
    .ld_ovf    (ld_ovf),
    .f_req     (f_req),
    .f_addr    (f_addr),
    .f_valid   (f_valid),
    .f_data    (f_data),
    .f_fault   (f_fault)
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  // Reference model: mode 0=run 1=load 2=flush, bytes held in a small list
  int          m_mode = 0;
  logic [31:0] m_mem [DEPTH];
  bit          m_known [DEPTH];
  logic [7:0]  m_b [4];
  int          m_nb = 0;
  int          m_cnt = 0;
  bit          m_ovf = 0;
  bit          m_v = 0;
  logic [31:0] m_d = '0;
  bit          m_dk = 1;
  bit          m_f = 0;

  function automatic void m_commit();
    logic [31:0] w;
    w = '0;
    for (int k = 0; k < m_nb; k++) w = w | (32'(m_b[k]) << (8 * k));
    if (m_cnt < DEPTH) begin
      m_mem[m_cnt] = w;
      m_known[m_cnt] = 1'b1;
      m_cnt++;
    end else begin
      m_ovf = 1'b1;
    end
    m_nb = 0;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode = 0; m_nb = 0; m_cnt = 0; m_ovf = 0;
      m_v = 0; m_d = '0; m_dk = 1; m_f = 0;
    end else begin
      m_v = f_req && (m_mode == 0);
      if (m_v) begin
        if (FAULT && int'(f_addr) >= DEPTH) begin
          m_d = NOP; m_dk = 1; m_f = 1;
        end else begin
          m_d  = m_mem[int'(f_addr) % DEPTH];
          m_dk = m_known[int'(f_addr) % DEPTH];
          m_f  = 0;
        end
      end
      case (m_mode)
        0: if (prog_mode) begin
          m_mode = 1; m_nb = 0; m_cnt = 0; m_ovf = 0;
        end
        1: begin
          if (ld_valid) begin
            m_b[m_nb] = ld_byte;
            m_nb++;
            if (m_nb == 4) m_commit();
          end
          if (!prog_mode) m_mode = (m_nb == 0) ? 0 : 2;
        end
        default: begin
          m_commit();
          m_mode = 0;
        end
      endcase
    end
  end

  bit chk_en = 0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("f_valid", 32'(f_valid), 32'(m_v));
      chk("ld_ready", 32'(ld_ready), 32'(m_mode == 1));
      chk("ld_count", 32'(ld_count), 32'(m_cnt));
      chk("ld_ovf", 32'(ld_ovf), 32'(m_ovf));
      if (m_dk) chk("f_data", f_data, m_d);
      if (m_v) chk("f_fault", 32'(f_fault), 32'(m_f));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(input logic [7:0] b);
    ld_valid = 1'b1;
    ld_byte  = b;
    tick();
    ld_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 0; k < 4; k++) send(w[8*k +: 8]);
  endtask

  task automatic fetch(input int a);
    f_req  = 1'b1;
    f_addr = AW'(a);
    tick();
    f_req  = 1'b0;
  endtask

  initial begin
    f_req = 1'b1;
    tick();
    chk_en = 1;
    tick();
    chk("rst_f_valid", 32'(f_valid), 32'd0);
    chk("rst_f_data", f_data, 32'd0);
    chk("rst_ld_ready", 32'(ld_ready), 32'd0);
    chk("rst_f_fault", 32'(f_fault), 32'd0);
    rst = 1'b0;
    tick();
    chk("first_f_valid", 32'(f_valid), 32'd1);
    f_req = 1'b0;
    tick();

    prog_mode = 1'b1;
    tick();
    foreach (m_b[i]) ;
    send(8'h13); send(8'h00); send(8'h00); send(8'h00);
    send(8'h93); send(8'h00); send(8'h10); send(8'h00);
    prog_mode = 1'b0;
    tick();
    fetch(0);
    chk("w0_nop", f_data, 32'h0000_0013);
    fetch(1);
    chk("w1_addi", f_data, 32'h0010_0093);
    chk("cnt_two", 32'(ld_count), 32'd2);

    prog_mode = 1'b1;
    tick();
    send(8'hAA); send(8'hBB); send(8'hCC); send(8'hDD); send(8'h11);
    prog_mode = 1'b0;
    tick();
    chk("flush_ready", 32'(ld_ready), 32'd0);
    tick();
    fetch(0);
    chk("flush_w0", f_data, 32'hDDCC_BBAA);
    fetch(1);
    chk("flush_w1", f_data, 32'h0000_0011);
    chk("flush_cnt", 32'(ld_count), 32'd2);

    prog_mode = 1'b1;
    tick();
    for (int w = 0; w <= DEPTH; w++) send_word(32'hA000_0000 | 32'(w));
    prog_mode = 1'b0;
    tick();
    chk("ovf_cnt", 32'(ld_count), 32'(DEPTH));
    chk("ovf_flag", 32'(ld_ovf), 32'd1);
    fetch(DEPTH - 1);
    chk("ovf_last_intact", f_data, 32'hA000_0000 | 32'(DEPTH - 1));
    prog_mode = 1'b1;
    tick();
    chk("reload_ovf_clr", 32'(ld_ovf), 32'd0);
    chk("reload_cnt_clr", 32'(ld_count), 32'd0);
    prog_mode = 1'b0;
    tick();

    fetch(11);
    if (FAULT) begin
      chk("oob_nop", f_data, NOP);
      chk("oob_fault", 32'(f_fault), 32'd1);
    end else begin
      chk("oob_wrap", f_data, 32'hA000_0003);
      chk("oob_nofault", 32'(f_fault), 32'd0);
    end

    prog_mode = 1'b1;
    tick();
    send_word(32'h1234_5678);
    send(8'hEE); send(8'hFF);
    rst = 1'b1;
    #1;
    chk("rst_abort_ready", 32'(ld_ready), 32'd0);
    prog_mode = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    chk("rst_abort_cnt", 32'(ld_count), 32'd0);
    fetch(0);
    chk("rst_keep_w0", f_data, 32'h1234_5678);
    fetch(1);
    chk("rst_no_partial", f_data, 32'hA000_0001);

    for (int s = 0; s < 30; s++) begin
      repeat ($urandom_range(2, 8)) begin
        f_req  = 1'($urandom);
        f_addr = AW'($urandom);
        tick();
      end
      prog_mode = 1'b1;
      begin
        int ncy;
        ncy = (s % 5 == 0) ? $urandom_range(30, 45) : $urandom_range(1, 16);
        for (int c = 0; c < ncy; c++) begin
          ld_valid = ($urandom % 4) != 0;
          ld_byte  = 8'($urandom);
          f_req    = 1'($urandom);
          f_addr   = AW'($urandom);
          if (c == ncy - 1 && $urandom_range(0, 1) == 1) prog_mode = 1'b0;
          tick();
        end
      end
      ld_valid  = 1'b0;
      prog_mode = 1'b0;
      f_req     = 1'($urandom);
      tick();
      tick();
    end
    f_req = 1'b0;
    tick();
    tick();
    chk_en = 0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
